// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding, port ids
// and the default RAM size used by the arbiter and the RAM models.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_t;

  localparam logic ARB_PORT_A = 1'b0;
  localparam logic ARB_PORT_B = 1'b1;

  localparam int unsigned ARB_DEFAULT_SIZE_BYTES = 32'd65536;

  // Byte address outside the RAM; widened so any address width compares safely.
  function automatic logic arb_out_of_range(input logic [63:0] addr, input logic [63:0] size_bytes);
    return (addr >= size_bytes);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr.sv
// Two-way round-robin grant: a lone request wins, a tie goes to the port
// that was not granted last. Purely combinational.
module rr_arbiter2
  import mem_port_arbiter_pkg::*;
(
  input  logic       req_a,
  input  logic       req_b,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // One-hot grant: bit 0 = port A, bit 1 = port B
  always_comb begin
    grant = 2'b00;
    if (req_a && req_b) begin
      if (last_grant == ARB_PORT_B) begin
        grant = 2'b01;
      end else begin
        grant = 2'b10;
      end
    end else if (req_a) begin
      grant = 2'b01;
    end else if (req_b) begin
      grant = 2'b10;
    end else begin
      grant = 2'b00;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between an instruction-fetch port (A)
// and a load/store port (B), serialising accesses with round-robin arbitration.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SIZE_BYTES  = ARB_DEFAULT_SIZE_BYTES,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    a_valid_i,
  output logic                    a_ready_o,
  input  logic [ADDR_WIDTH-1:0]   a_addr_i,
  input  logic [DATA_WIDTH-1:0]   a_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] a_we_i,
  output logic [DATA_WIDTH-1:0]   a_rdata_o,
  output logic                    a_err_o,
  input  logic                    b_valid_i,
  output logic                    b_ready_o,
  input  logic [ADDR_WIDTH-1:0]   b_addr_i,
  input  logic [DATA_WIDTH-1:0]   b_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] b_we_i,
  output logic [DATA_WIDTH-1:0]   b_rdata_o,
  output logic                    b_err_o,
  output logic                    mem_req_o,
  output logic [ADDR_WIDTH-3:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_we_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
  localparam logic [1:0]  LAT_LOAD = 2'(MEM_LATENCY - 1);

  arb_state_t              state_r;
  logic                    last_grant_r;
  logic                    grant_r;
  logic                    oor_r;
  logic                    read_r;
  logic [1:0]              cnt_r;
  logic                    mem_req_r;
  logic [ADDR_WIDTH-3:0]   mem_addr_r;
  logic [DATA_WIDTH-1:0]   mem_wdata_r;
  logic [BE_WIDTH-1:0]     mem_we_r;
  logic                    a_ready_r;
  logic                    b_ready_r;
  logic                    a_err_r;
  logic                    b_err_r;

  logic [1:0]              gnt_s;
  logic                    sel_b_s;
  logic [ADDR_WIDTH-1:0]   sel_addr_s;
  logic [DATA_WIDTH-1:0]   sel_wdata_s;
  logic [BE_WIDTH-1:0]     sel_we_s;
  logic                    oor_s;
  logic                    enter_resp_s;

  rr_arbiter2 u_rr (
    .req_a      (a_valid_i),
    .req_b      (b_valid_i),
    .last_grant (last_grant_r),
    .grant      (gnt_s)
  );

  // Select the winning requester's fields and range-check its address
  always_comb begin
    sel_b_s = gnt_s[1];
    if (sel_b_s) begin
      sel_addr_s  = b_addr_i;
      sel_wdata_s = b_wdata_i;
      sel_we_s    = b_we_i;
    end else begin
      sel_addr_s  = a_addr_i;
      sel_wdata_s = a_wdata_i;
      sel_we_s    = a_we_i;
    end
    oor_s = arb_out_of_range(64'(sel_addr_s), 64'(SIZE_BYTES));
  end

  // The response cycle follows ISSUE directly for oor or single-cycle RAMs
  always_comb begin
    case (state_r)
      ARB_ISSUE: enter_resp_s = oor_r || (LAT_LOAD == 2'd0);
      ARB_WAIT:  enter_resp_s = (cnt_r <= 2'd1);
      default:   enter_resp_s = 1'b0;
    endcase
  end

  // Arbitration FSM with registered RAM strobe and request fields
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ARB_IDLE;
      last_grant_r <= ARB_PORT_B;
      grant_r      <= ARB_PORT_A;
      oor_r        <= 1'b0;
      read_r       <= 1'b0;
      cnt_r        <= 2'd0;
      mem_req_r    <= 1'b0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= '0;
      mem_we_r     <= '0;
    end else begin
      case (state_r)
        ARB_IDLE: begin
          if (gnt_s != 2'b00) begin
            grant_r      <= sel_b_s;
            last_grant_r <= sel_b_s;
            oor_r        <= oor_s;
            read_r       <= (sel_we_s == '0);
            mem_req_r    <= ~oor_s;
            if (oor_s) begin
              mem_addr_r  <= '0;
              mem_wdata_r <= '0;
              mem_we_r    <= '0;
            end else begin
              mem_addr_r  <= sel_addr_s[ADDR_WIDTH-1:2];
              mem_wdata_r <= sel_wdata_s;
              mem_we_r    <= sel_we_s;
            end
            state_r <= ARB_ISSUE;
          end else begin
            state_r <= ARB_IDLE;
          end
        end
        ARB_ISSUE: begin
          mem_req_r   <= 1'b0;
          mem_addr_r  <= '0;
          mem_wdata_r <= '0;
          mem_we_r    <= '0;
          cnt_r       <= LAT_LOAD;
          state_r     <= enter_resp_s ? ARB_RESP : ARB_WAIT;
        end
        ARB_WAIT: begin
          cnt_r   <= cnt_r - 2'd1;
          state_r <= enter_resp_s ? ARB_RESP : ARB_WAIT;
        end
        ARB_RESP: begin
          // Valid is deliberately ignored here while the requester drops it
          state_r <= ARB_IDLE;
        end
        default: begin
          state_r <= ARB_IDLE;
        end
      endcase
    end
  end

  // One-cycle ready/err pulse on the granted port during RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      a_ready_r <= 1'b0;
      b_ready_r <= 1'b0;
      a_err_r   <= 1'b0;
      b_err_r   <= 1'b0;
    end else if (enter_resp_s) begin
      a_ready_r <= (grant_r == ARB_PORT_A);
      b_ready_r <= (grant_r == ARB_PORT_B);
      a_err_r   <= (grant_r == ARB_PORT_A) && oor_r;
      b_err_r   <= (grant_r == ARB_PORT_B) && oor_r;
    end else begin
      a_ready_r <= 1'b0;
      b_ready_r <= 1'b0;
      a_err_r   <= 1'b0;
      b_err_r   <= 1'b0;
    end
  end

  assign a_ready_o   = a_ready_r;
  assign b_ready_o   = b_ready_r;
  assign a_err_o     = a_err_r;
  assign b_err_o     = b_err_r;
  // RAM data arrives in the RESP cycle itself, so it is gated rather than registered
  assign a_rdata_o   = (a_ready_r && read_r && !oor_r) ? mem_rdata_i : '0;
  assign b_rdata_o   = (b_ready_r && read_r && !oor_r) ? mem_rdata_i : '0;
  assign mem_req_o   = mem_req_r;
  assign mem_addr_o  = mem_addr_r;
  assign mem_wdata_o = mem_wdata_r;
  assign mem_we_o    = mem_we_r;

endmodule
